// File: rtl/weight_agg_pkg.sv
// weight_agg_pkg
//   Shared types and default sizes for the weight input aggregator.
//   - agg_state_t : FSM states of the aggregator (FILL / WAIT_SWITCH)
//   - DEF_OC0, DEF_DATA_WIDTH : default packing factor and word width
//   - DEF_ENTRY_WIDTH : width of one packed bank entry (OC0 * DATA_WIDTH)
package weight_agg_pkg;

    typedef enum logic {
        FILL        = 1'b0,
        WAIT_SWITCH = 1'b1
    } agg_state_t;

    localparam int DEF_OC0         = 4;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_ENTRY_WIDTH = DEF_OC0 * DEF_DATA_WIDTH;

endpackage

// File: rtl/weight_entry_packer.sv
// weight_entry_packer
//   Collects OC0 accepted words into one bank entry.
//   Ports:
//     clk, rst_n   : clock, synchronous active-high reset
//     clear        : drop any partial entry and restart at lane 0
//     accept       : a word is taken this cycle
//     data         : the word being taken
//     entry_done   : combinational, high when the accepted word completes an entry
//     entry_data   : packed entry (lane 0 in LSBs), valid with entry_done
module weight_entry_packer
    import weight_agg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OC0        = DEF_OC0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      accept,
    input  logic [DATA_WIDTH-1:0]     data,
    output logic                      entry_done,
    output logic [OC0*DATA_WIDTH-1:0] entry_data
);

    localparam int CNT_W = (OC0 > 1) ? $clog2(OC0) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(OC0 - 1);

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] lanes [OC0];

    // Lane counter is control: reset and clear both restart it.
    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (cnt == LAST_LANE) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Lane storage is datapath only; stale contents are never exposed because
    // an entry is emitted only after every lane has been rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            lanes[cnt] <= data;
        end
    end

    assign entry_done = accept && (cnt == LAST_LANE);

    // The final lane is taken straight from the input so the entry is
    // available in the same cycle its last word is accepted.
    always_comb begin
        entry_data = '0;
        for (int i = 0; i < OC0; i++) begin
            entry_data[i*DATA_WIDTH +: DATA_WIDTH] = (i == OC0 - 1) ? data : lanes[i];
        end
    end

endmodule

// File: rtl/weight_input_aggregator.sv
// weight_input_aggregator
//   Packs a valid/ready stream of weight words into bank entries and writes
//   them into the write bank of the weight double buffer. After the last
//   entry of a bank it pulses bank_full and stalls until bank_switch.
//   Ports:
//     clk, rst_n            : clock, synchronous active-high reset
//     config_enable/_data   : load bank depth (entries), restart the bank
//     weights_data/_valid   : incoming word stream
//     weights_ready         : stream can be accepted this cycle
//     wen, waddr, wdata     : registered bank write (one cycle after entry completes)
//     bank_full             : pulse with the wen of the last entry
//     bank_switch           : consumer acknowledges swap (only in WAIT_SWITCH)
//   Optional build macro WEIGHT_AGG_STATUS_EN adds output fill_level, the
//   number of entries written into the current bank.
module weight_input_aggregator
    import weight_agg_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int OC0             = DEF_OC0,
    parameter int BANK_ADDR_WIDTH = 32,
    parameter int CONFIG_WIDTH    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       config_enable,
    input  logic [CONFIG_WIDTH-1:0]    config_data,
    input  logic [DATA_WIDTH-1:0]      weights_data,
    input  logic                       weights_valid,
    output logic                       weights_ready,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] waddr,
    output logic [OC0*DATA_WIDTH-1:0]  wdata,
    output logic                       bank_full,
    input  logic                       bank_switch
`ifdef WEIGHT_AGG_STATUS_EN
    ,
    output logic [BANK_ADDR_WIDTH-1:0] fill_level
`endif
);

    localparam int EW = OC0 * DATA_WIDTH;

    agg_state_t                 state, state_nxt;
    logic [BANK_ADDR_WIDTH-1:0] depth;
    logic [BANK_ADDR_WIDTH-1:0] idx;
    logic [BANK_ADDR_WIDTH-1:0] last_idx;
    logic                       accept_p0;
    logic                       entry_vld_p0;
    logic [EW-1:0]              entry_data_p0;
    logic                       is_last;

    // A config write wins over a simultaneous handshake; the word is dropped.
    assign accept_p0 = weights_valid && weights_ready && !config_enable;

    // Depth 0 behaves as a single-entry bank.
    assign last_idx = (depth == '0) ? '0 : depth - BANK_ADDR_WIDTH'(1);
    assign is_last  = (idx == last_idx);

    weight_entry_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .OC0        (OC0)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (config_enable),
        .accept     (accept_p0),
        .data       (weights_data),
        .entry_done (entry_vld_p0),
        .entry_data (entry_data_p0)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (config_enable) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:        if (entry_vld_p0 && is_last) state_nxt = WAIT_SWITCH;
                WAIT_SWITCH: if (bank_switch)             state_nxt = FILL;
                default:                                  state_nxt = FILL;
            endcase
        end
    end

    // Ready is held low while reset is applied so nothing is accepted then.
    always_comb begin
        weights_ready = (state == FILL) && !rst_n;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            depth <= '0;
            idx   <= '0;
        end else if (config_enable) begin
            depth <= config_data[BANK_ADDR_WIDTH-1:0];
            idx   <= '0;
        end else if (entry_vld_p0) begin
            idx <= is_last ? '0 : idx + BANK_ADDR_WIDTH'(1);
        end
    end

    // ---- p0 -> p1: registered bank write ----
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wen       <= 1'b0;
            bank_full <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            wen       <= entry_vld_p0;
            bank_full <= entry_vld_p0 && is_last;
            if (entry_vld_p0) begin
                waddr <= idx;
                wdata <= entry_data_p0;
            end
        end
    end

`ifdef WEIGHT_AGG_STATUS_EN
    // Counts alongside wen; naturally sits at depth while waiting for the swap.
    always_ff @(posedge clk) begin
        if (rst_n || config_enable) begin
            fill_level <= '0;
        end else if (state == WAIT_SWITCH && bank_switch) begin
            fill_level <= '0;
        end else if (entry_vld_p0) begin
            fill_level <= fill_level + BANK_ADDR_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_weight_input_aggregator.sv
module tb_weight_input_aggregator;

    localparam int DW  = 16;
    localparam int OC0 = 4;
    localparam int BAW = 32;
    localparam int CW  = 32;
    localparam int EW  = OC0 * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           config_enable = 1'b0;
    logic [CW-1:0]  config_data = '0;
    logic [DW-1:0]  weights_data = '0;
    logic           weights_valid = 1'b0;
    logic           weights_ready;
    logic           wen;
    logic [BAW-1:0] waddr;
    logic [EW-1:0]  wdata;
    logic           bank_full;
    logic           bank_switch = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    weight_input_aggregator #(
        .DATA_WIDTH      (DW),
        .OC0             (OC0),
        .BANK_ADDR_WIDTH (BAW),
        .CONFIG_WIDTH    (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst),
        .config_enable (config_enable),
        .config_data   (config_data),
        .weights_data  (weights_data),
        .weights_valid (weights_valid),
        .weights_ready (weights_ready),
        .wen           (wen),
        .waddr         (waddr),
        .wdata         (wdata),
        .bank_full     (bank_full),
        .bank_switch   (bank_switch)
    );

    // Reference model: queue of accepted words, entry counter, stall flag.
    int             m_depth = 1;
    logic [DW-1:0]  m_words [$];
    int             m_idx   = 0;
    bit             m_stall = 0;
    int             m_accepted = 0;
    logic           exp_wen  = 1'b0;
    logic           exp_full = 1'b0;
    logic [BAW-1:0] exp_waddr = '0;
    logic [EW-1:0]  exp_wdata = '0;

    function automatic logic exp_ready();
        return !rst && !m_stall;
    endfunction

    // Apply inputs for one clock, advance the model across the edge, and
    // return #1 after the edge with outputs settled.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit sw,
                        input bit ce, input logic [CW-1:0] cd);
        bit was_stall;
        weights_valid = v;
        weights_data  = d;
        bank_switch   = sw;
        config_enable = ce;
        config_data   = cd;
        exp_wen  = 1'b0;
        exp_full = 1'b0;
        was_stall = m_stall;
        if (rst) begin
            m_depth = 1; m_words.delete(); m_idx = 0; m_stall = 0;
            exp_waddr = '0; exp_wdata = '0;
        end else if (ce) begin
            m_depth = (cd == 0) ? 1 : int'(cd);
            m_words.delete(); m_idx = 0; m_stall = 0;
        end else begin
            if (v && !m_stall) begin
                m_words.push_back(d);
                m_accepted++;
                if (m_words.size() == OC0) begin
                    for (int i = 0; i < OC0; i++) exp_wdata[i*DW +: DW] = m_words[i];
                    exp_wen   = 1'b1;
                    exp_waddr = BAW'(m_idx);
                    exp_full  = (m_idx == m_depth - 1);
                    m_words.delete();
                    if (exp_full) begin
                        m_idx = 0; m_stall = 1;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (was_stall && sw) m_stall = 0;
        end
        @(posedge clk);
        #1;
        bank_switch   = 1'b0;
        config_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        checks++;
        if (weights_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b want=0", weights_ready);
        end
        checks++;
        if (wen !== 1'b0 || bank_full !== 1'b0 || waddr !== '0 || wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got wen=%b full=%b waddr=%0h wdata=%0h want all 0",
                     wen, bank_full, waddr, wdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (weights_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got=%b want=1", weights_ready);
        end
    endtask

    task automatic test_basic();
        step(0, '0, 0, 1, 32'd2);
        for (int w = 1; w <= 8; w++) begin
            checks++;
            if (weights_ready !== exp_ready()) begin
                failures++; $display("FAIL basic_ready w=%0d got=%b want=%b", w, weights_ready, exp_ready());
            end
            step(1, DW'(w), 0, 0, '0);
            checks++;
            if (wen !== exp_wen || bank_full !== exp_full ||
                (exp_wen && (waddr !== exp_waddr || wdata !== exp_wdata))) begin
                failures++;
                $display("FAIL basic_write w=%0d got wen=%b full=%b addr=%0h data=%0h want wen=%b full=%b addr=%0h data=%0h",
                         w, wen, bank_full, waddr, wdata, exp_wen, exp_full, exp_waddr, exp_wdata);
            end
            if (w == 4) begin
                checks++;
                if (wen !== 1'b1 || waddr !== 32'd0 || wdata !== 64'h0004_0003_0002_0001 || bank_full !== 1'b0) begin
                    failures++; $display("FAIL basic_entry0 got wen=%b addr=%0h data=%0h full=%b", wen, waddr, wdata, bank_full);
                end
            end
            if (w == 8) begin
                checks++;
                if (wen !== 1'b1 || waddr !== 32'd1 || wdata !== 64'h0008_0007_0006_0005 || bank_full !== 1'b1) begin
                    failures++; $display("FAIL basic_entry1 got wen=%b addr=%0h data=%0h full=%b", wen, waddr, wdata, bank_full);
                end
            end
        end
        checks++;
        if (weights_ready !== 1'b0) begin
            failures++; $display("FAIL basic_stall_ready got=%b want=0", weights_ready);
        end
    endtask

    task automatic test_switch();
        int w;
        int start;
        bit seen;
        w = 9;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (weights_ready !== 1'b0 || exp_ready() !== 1'b0) begin
                failures++; $display("FAIL switch_wait_ready c=%0d got=%b want=0", c, weights_ready);
            end
            step(1, DW'(w), (c == 5), 0, '0);
        end
        checks++;
        if (weights_ready !== 1'b1) begin
            failures++; $display("FAIL switch_resume_ready got=%b want=1", weights_ready);
        end
        start = m_accepted;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (exp_ready()) w = 9 + (m_accepted - start);
            step(1, DW'(w), 0, 0, '0);
            checks++;
            if (wen !== exp_wen || bank_full !== exp_full ||
                (exp_wen && (waddr !== exp_waddr || wdata !== exp_wdata))) begin
                failures++;
                $display("FAIL switch_write got wen=%b addr=%0h data=%0h want wen=%b addr=%0h data=%0h",
                         wen, waddr, wdata, exp_wen, exp_waddr, exp_wdata);
            end
            if (wen === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || waddr !== 32'd0 || wdata !== 64'h000c_000b_000a_0009) begin
            failures++; $display("FAIL switch_entry seen=%0d addr=%0h data=%0h want addr=0 data=000c000b000a0009",
                                 seen, waddr, wdata);
        end
    endtask

    task automatic test_random_gaps();
        int dut_wens;
        logic [BAW-1:0] want_addr;
        dut_wens = 0;
        want_addr = '0;
        step(0, '0, 0, 1, 32'd3);
        for (int c = 0; c < 120; c++) begin
            checks++;
            if (weights_ready !== exp_ready()) begin
                failures++; $display("FAIL gaps_ready c=%0d got=%b want=%b", c, weights_ready, exp_ready());
            end
            step(bit'($urandom_range(0, 1)), DW'($urandom_range(0, 65535)), 0, 0, '0);
            checks++;
            if (wen !== exp_wen || bank_full !== exp_full ||
                (exp_wen && (waddr !== exp_waddr || wdata !== exp_wdata))) begin
                failures++;
                $display("FAIL gaps_write c=%0d got wen=%b full=%b addr=%0h data=%0h want wen=%b full=%b addr=%0h data=%0h",
                         c, wen, bank_full, waddr, wdata, exp_wen, exp_full, exp_waddr, exp_wdata);
            end
            if (wen === 1'b1) begin
                checks++;
                if (waddr !== want_addr) begin
                    failures++; $display("FAIL gaps_order got=%0h want=%0h", waddr, want_addr);
                end
                want_addr = want_addr + 1;
                dut_wens++;
            end
        end
        checks++;
        if (dut_wens !== 3) begin
            failures++; $display("FAIL gaps_entry_count got=%0d want=3", dut_wens);
        end
    endtask

    task automatic test_config_abort();
        step(0, '0, 0, 1, 32'd4);
        step(1, 16'haaaa, 0, 0, '0);
        step(1, 16'hbbbb, 0, 0, '0);
        step(1, 16'hcccc, 0, 1, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(1, DW'(16'h0100 + k), 0, 0, '0);
            checks++;
            if (wen !== exp_wen || bank_full !== exp_full ||
                (exp_wen && (waddr !== exp_waddr || wdata !== exp_wdata))) begin
                failures++;
                $display("FAIL abort_write k=%0d got wen=%b full=%b addr=%0h data=%0h want wen=%b full=%b addr=%0h data=%0h",
                         k, wen, bank_full, waddr, wdata, exp_wen, exp_full, exp_waddr, exp_wdata);
            end
        end
        checks++;
        if (wen !== 1'b1 || bank_full !== 1'b1 || waddr !== 32'd0 || wdata !== 64'h0103_0102_0101_0100) begin
            failures++; $display("FAIL abort_entry got wen=%b full=%b addr=%0h data=%0h", wen, bank_full, waddr, wdata);
        end
    endtask

    task automatic test_switch_in_fill();
        int fulls;
        logic [BAW-1:0] full_addr;
        fulls = 0;
        full_addr = '1;
        step(0, '0, 0, 1, 32'd4);
        for (int k = 0; k < 4; k++) step(1, DW'($urandom_range(0, 65535)), 0, 0, '0);
        step(0, '0, 1, 0, '0);
        checks++;
        if (weights_ready !== 1'b1) begin
            failures++; $display("FAIL fill_switch_ready got=%b want=1", weights_ready);
        end
        for (int k = 0; k < 12; k++) begin
            step(1, DW'($urandom_range(0, 65535)), 0, 0, '0);
            checks++;
            if (wen !== exp_wen || bank_full !== exp_full ||
                (exp_wen && (waddr !== exp_waddr || wdata !== exp_wdata))) begin
                failures++;
                $display("FAIL fill_switch_write k=%0d got wen=%b full=%b addr=%0h want wen=%b full=%b addr=%0h",
                         k, wen, bank_full, waddr, exp_wen, exp_full, exp_waddr);
            end
            if (bank_full === 1'b1) begin
                fulls++; full_addr = waddr;
            end
        end
        checks++;
        if (fulls !== 1 || full_addr !== 32'd3) begin
            failures++; $display("FAIL fill_switch_full got count=%0d addr=%0h want count=1 addr=3", fulls, full_addr);
        end
    endtask

    task automatic test_mid_reset();
        logic [EW-1:0] want;
        logic [DW-1:0] d;
        step(0, '0, 0, 1, 32'd2);
        for (int k = 0; k < 3; k++) step(1, DW'(16'h0500 + k), 0, 0, '0);
        rst = 1'b1;
        step(1, 16'h0503, 0, 0, '0);
        checks++;
        if (weights_ready !== 1'b0 || wen !== 1'b0 || bank_full !== 1'b0 || waddr !== '0 || wdata !== '0) begin
            failures++; $display("FAIL midreset_outputs got rdy=%b wen=%b full=%b addr=%0h data=%0h want all 0",
                                 weights_ready, wen, bank_full, waddr, wdata);
        end
        rst = 1'b0;
        step(0, '0, 0, 1, 32'd2);
        for (int k = 0; k < 4; k++) begin
            d = DW'($urandom_range(0, 65535));
            want[k*DW +: DW] = d;
            step(1, d, 0, 0, '0);
        end
        checks++;
        if (wen !== 1'b1 || waddr !== 32'd0 || wdata !== want || bank_full !== 1'b0) begin
            failures++; $display("FAIL midreset_entry got wen=%b addr=%0h data=%0h full=%b want wen=1 addr=0 data=%0h full=0",
                                 wen, waddr, wdata, bank_full, want);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_switch();
        test_random_gaps();
        test_config_abort();
        test_switch_in_fill();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
